mul_seq_32b: RTL
================

MUL_SEQ_32B -- requirements
Module: mul_seq_32b

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port a, input, 32, unsigned multiplicand; sampled on the accept cycle only.
REQ-006 SHALL have port b, input, 32, unsigned multiplier; sampled on the accept cycle only.
REQ-007 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking a valid result.
REQ-009 SHALL have port hi, output, 32, upper half of the 64-bit product.
REQ-010 SHALL have port lo, output, 32, lower half of the 64-bit product; this feeds the downstream 32-bit zero-flag detector.

Function
REQ-011 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-012 SHALL accept start only in IDLE; an accept cycle is IDLE with start=1.
REQ-013 On accept: latch a into the multiplicand register, load b into the multiplier shift register, clear the 33-bit accumulator, clear the 6-bit step counter, and move to RUN.
REQ-014 Each RUN cycle: if multiplier bit0=1, add the multiplicand to accumulator[31:0] and keep the carry; then shift {carry, acc, mplier} right by 1 and increment the counter.
REQ-015 SHALL leave RUN after exactly 32 RUN cycles (counter reaches 31 and that step completes) and enter DONE.
REQ-016 In DONE: assert done=1 for exactly one cycle, with hi=acc and lo=mplier holding the full unsigned product; the next state is IDLE unconditionally.
REQ-017 Latency: for an accept at cycle N, done SHALL be high at cycle N+33.
REQ-018 hi and lo SHALL hold their values from the DONE cycle until the next accept; they SHALL NOT show intermediate RUN values.
REQ-019 start while in RUN or DONE SHALL be ignored, with no queuing; a, b and start changing mid-operation SHALL NOT affect the result.
REQ-020 Arithmetic: unsigned only; the product SHALL be exact modulo 2^64; no overflow indication.
REQ-021 Back-to-back operation: the earliest next accept is the cycle after DONE (IDLE), giving 34 cycles per operation.

Reset
REQ-022 With rst=1 at a clock edge, the block SHALL go to IDLE with busy=0, done=0, hi=0, lo=0, and all internal registers cleared.
REQ-023 Reset during RUN or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-024 rst SHALL take priority over start in the same cycle.

Structure
REQ-025 The shared package SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the constants MUL_WIDTH=32 and MUL_STEPS=32.
REQ-026 The 32-bit add with carry-out SHALL be a sub-module named add_32b (inputs a, b; outputs sum and cout); all other logic SHALL be in mul_seq_32b.

Verification
REQ-027 a=3, b=5, start for 1 cycle -> done at N+33; hi=0x00000000, lo=0x0000000F; busy high from N+1 to N+33.
REQ-028 a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-029 a=0x12345678, b=0 -> hi=0, lo=0; the downstream zero detector reports zero.
REQ-030 Accept a=2, b=7, then pulse start with a=9, b=9 at N+10 -> a single done at N+33 with lo=0x0000000E; no second done.
REQ-031 Accept a=4, b=4, then assert rst at N+20 -> IDLE, busy=0, hi=lo=0 at N+21, and no done; a new start a=6, b=7 -> lo=0x0000002A.
REQ-032 Randomized back-to-back pairs, 1000 of them, checked against a 64-bit reference product -> all match, with exactly 34 cycles between accepts.

Source files
------------

// File: rtl/mul_seq_32b_pkg.sv
// Shared definitions for the sequential 32x32 shift-and-add multiplier.
package mul_seq_32b_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_STEPS = 32;

  // Control states: waiting for a request, iterating, presenting the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Step counter value on which the final iteration completes.
  function automatic logic [5:0] last_step();
    return 6'(MUL_STEPS - 1);
  endfunction

endpackage

// File: rtl/add_32b.sv
// 32-bit unsigned adder with carry-out, used once per multiply step.
module add_32b
  import mul_seq_32b_pkg::*;
(
  input  logic [MUL_WIDTH-1:0] a,
  input  logic [MUL_WIDTH-1:0] b,
  output logic [MUL_WIDTH-1:0] sum,
  output logic                 cout
);

  // Zero-extend both operands so the top bit of the result is the carry.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/mul_seq_32b.sv
// Sequential unsigned multiplier: one shift-and-add step per clock,
// 34 cycles per operation including accept and result cycles.
module mul_seq_32b
  import mul_seq_32b_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mul_state_e           state_r;
  mul_state_e           state_nx_s;
  logic [MUL_WIDTH-1:0] mcand_r;
  logic [MUL_WIDTH-1:0] mplier_r;
  logic [MUL_WIDTH:0]   acc_r;
  logic [5:0]           cnt_r;
  logic [MUL_WIDTH-1:0] hi_r;
  logic [MUL_WIDTH-1:0] lo_r;
  logic                 done_r;
  logic                 busy_r;

  logic                 accept_s;
  logic                 last_s;
  logic [MUL_WIDTH-1:0] sum_s;
  logic                 cout_s;
  logic [MUL_WIDTH:0]   step_s;

  add_32b u_add (
    .a    (acc_r[MUL_WIDTH-1:0]),
    .b    (mcand_r),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Partial sum for this step: add the multiplicand only when the multiplier LSB is set.
  always_comb begin
    step_s = {acc_r[MUL_WIDTH], acc_r[MUL_WIDTH-1:0]};
    if (mplier_r[0]) begin
      step_s = {cout_s, sum_s};
    end else begin
      step_s = {acc_r[MUL_WIDTH], acc_r[MUL_WIDTH-1:0]};
    end
  end

  // Next-state decode plus accept / final-step strobes.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s   = 1'b1;
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == last_step()) begin
          last_s     = 1'b1;
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath: load on accept, shift {carry, acc, mplier} right each RUN cycle,
  // capture the product into the output registers only on the final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r  <= 32'd0;
      mplier_r <= 32'd0;
      acc_r    <= 33'd0;
      cnt_r    <= 6'd0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        mcand_r  <= a;
        mplier_r <= b;
        acc_r    <= 33'd0;
        cnt_r    <= 6'd0;
      end else if (state_r == RUN) begin
        acc_r    <= {1'b0, step_s[MUL_WIDTH:1]};
        mplier_r <= {step_s[0], mplier_r[MUL_WIDTH-1:1]};
        cnt_r    <= cnt_r + 6'd1;
      end
      if (last_s) begin
        hi_r <= step_s[MUL_WIDTH:1];
        lo_r <= {step_s[0], mplier_r[MUL_WIDTH-1:1]};
      end
      done_r <= last_s;
      busy_r <= (state_nx_s != IDLE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule
